fft_frame_loader: RTL and testbench

Upstream feeder for the 8-point FFT stage. It accepts a serial stream of signed integer real samples over a valid/ready handshake and converts each one to a 64-bit complex Q16.16 word: {real[31:0], imag[31:0]}, imag = 0. It collects eight samples into a frame and presents them in parallel on `f0`..`f7` with a valid/ready handshake. Double buffering (fill buffer plus output hold registers) lets a new frame fill while the previous one waits to be consumed.

---
 rtl/fft_pkg.sv | 27 ++
 rtl/fft_frame_loader.sv | 119 +++++++++++
 tb/tb_fft_frame_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the 8-point FFT datapath: frame geometry,
// complex word layout and the integer-to-Q16.16 conversion.
package fft_pkg;

   localparam int FFT_N      = 8;
   localparam int FFT_WORD_W = 64;
   localparam int FFT_Q_FRAC = 16;

   typedef struct packed {
      logic [31:0] re;
      logic [31:0] im;
   } cplx_t;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_FULL = 1'b1
   } ld_state_e;

   // Caller sign-extends the sample to 32 bits; the shift places it in the integer field.
   function automatic cplx_t to_q(input logic signed [31:0] s, input int frac);
      cplx_t c;
      c.re = s <<< frac;
      c.im = '0;
      return c;
   endfunction

endpackage

// File: rtl/fft_frame_loader.sv
// Serial-to-parallel frame loader for the FFT stage: converts real samples to
// complex Q words and double-buffers 8-sample frames behind a valid/ready pair.
module fft_frame_loader
   import fft_pkg::*;
#(
   parameter int SAMPLE_W = 16,
   parameter int FRAC_W   = FFT_Q_FRAC
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic signed [SAMPLE_W-1:0] in_data,
   input  logic                       in_sof,
   output logic                       in_ready,
   output logic [FFT_WORD_W-1:0]      f0,
   output logic [FFT_WORD_W-1:0]      f1,
   output logic [FFT_WORD_W-1:0]      f2,
   output logic [FFT_WORD_W-1:0]      f3,
   output logic [FFT_WORD_W-1:0]      f4,
   output logic [FFT_WORD_W-1:0]      f5,
   output logic [FFT_WORD_W-1:0]      f6,
   output logic [FFT_WORD_W-1:0]      f7,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [7:0]                 frame_cnt,
   output logic                       sof_err
);

   ld_state_e   state_q, state_d;
   cplx_t       buf_q [FFT_N];
   cplx_t       buf_d [FFT_N];
   cplx_t       f_q   [FFT_N];
   cplx_t       f_d   [FFT_N];
   logic [2:0]  idx_q, idx_d, wr_idx;
   logic        ov_q, ov_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        sof_err_q, sof_err_d;
   logic signed [31:0] samp_ext;
   cplx_t       word;
   logic        accept, consume;

   assign samp_ext = 32'(in_data);
   assign word     = to_q(samp_ext, FRAC_W);

   // State decode only: out_ready never reaches in_ready combinationally.
   assign in_ready = rst && (state_q == ST_FILL);
   assign accept   = in_valid && in_ready;
   assign consume  = ov_q && out_ready;
   assign wr_idx   = in_sof ? 3'd0 : idx_q;

   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      f_d       = f_q;
      idx_d     = idx_q;
      ov_d      = ov_q;
      cnt_d     = cnt_q;
      sof_err_d = 1'b0;
      if (accept) begin
         buf_d[wr_idx] = word;
         idx_d         = wr_idx + 3'd1;
         sof_err_d     = in_sof && (idx_q != 3'd0);
      end
      if (state_q == ST_FILL && accept && wr_idx == 3'(FFT_N - 1)) begin
         // Slot free or draining this edge: the completed frame bypasses FULL.
         if (!ov_q || out_ready) begin
            f_d   = buf_d;
            ov_d  = 1'b1;
            cnt_d = cnt_q + 8'd1;
         end else begin
            state_d = ST_FULL;
         end
      end else if (state_q == ST_FULL && consume) begin
         f_d     = buf_q;
         ov_d    = 1'b1;
         cnt_d   = cnt_q + 8'd1;
         state_d = ST_FILL;
      end else if (consume) begin
         ov_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_FILL;
         idx_q     <= '0;
         ov_q      <= 1'b0;
         cnt_q     <= '0;
         sof_err_q <= 1'b0;
         for (int i = 0; i < FFT_N; i++) begin
            buf_q[i] <= '0;
            f_q[i]   <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ov_q      <= ov_d;
         cnt_q     <= cnt_d;
         sof_err_q <= sof_err_d;
         for (int i = 0; i < FFT_N; i++) begin
            buf_q[i] <= buf_d[i];
            f_q[i]   <= f_d[i];
         end
      end
   end

   assign f0        = f_q[0];
   assign f1        = f_q[1];
   assign f2        = f_q[2];
   assign f3        = f_q[3];
   assign f4        = f_q[4];
   assign f5        = f_q[5];
   assign f6        = f_q[6];
   assign f7        = f_q[7];
   assign out_valid = ov_q;
   assign frame_cnt = cnt_q;
   assign sof_err   = sof_err_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: a conversion vector table streamed as one
// frame, plus hand sequences for backpressure, SOF truncation, reset and wrap.
module tb_fft_frame_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_sof = 1'b0;
   logic        in_ready;
   logic [63:0] f0, f1, f2, f3, f4, f5, f6, f7;
   logic [63:0] fo [8];
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [7:0]  frame_cnt;
   logic        sof_err;

   int nvec = 0;
   int nerr = 0;
   int sof_pulses = 0;
   int drops = 0;
   bit mon_en = 1'b0;

   always #5 clk = ~clk;

   fft_frame_loader #(.SAMPLE_W(16), .FRAC_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof), .in_ready(in_ready),
      .f0(f0), .f1(f1), .f2(f2), .f3(f3), .f4(f4), .f5(f5), .f6(f6), .f7(f7),
      .out_valid(out_valid), .out_ready(out_ready),
      .frame_cnt(frame_cnt), .sof_err(sof_err)
   );

   assign fo[0] = f0; assign fo[1] = f1; assign fo[2] = f2; assign fo[3] = f3;
   assign fo[4] = f4; assign fo[5] = f5; assign fo[6] = f6; assign fo[7] = f7;

   always @(posedge clk) begin
      if (sof_err) sof_pulses <= sof_pulses + 1;
      if (mon_en && rst && in_valid && !in_ready) drops <= drops + 1;
   end

   typedef struct {
      logic [15:0] data;
      logic [63:0] exp_word;
   } vec_t;

   vec_t tbl [8];

   // Q16.16 real with zero imag: the 16-bit sample lands in the top half of re.
   function automatic logic [63:0] w(input logic [15:0] d);
      return {d, 16'h0000, 32'h0000_0000};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [15:0] d, input logic s);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = s;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         nvec++; nerr++;
         $display("FAIL send_timeout: in_ready stuck at %b, expected 1", in_ready);
      end else begin
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   initial begin
      logic [15:0] last_v;
      tbl[0] = '{16'h0001, 64'h00010000_00000000};
      tbl[1] = '{16'hFFFF, 64'hFFFF0000_00000000};
      tbl[2] = '{16'h8000, 64'h80000000_00000000};
      tbl[3] = '{16'h7FFF, 64'h7FFF0000_00000000};
      tbl[4] = '{16'h0000, 64'h00000000_00000000};
      tbl[5] = '{16'h1234, 64'h12340000_00000000};
      tbl[6] = '{16'hFFFE, 64'hFFFE0000_00000000};
      tbl[7] = '{16'h00FF, 64'h00FF0000_00000000};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_f0", f0, 0);
      chk("rst_sof_err", sof_err, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("rel_in_ready", in_ready, 1);

      // first frame 1..8, slot free
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
      chk("f1_out_valid", out_valid, 1);
      chk("f1_f0", f0, 64'h00010000_00000000);
      chk("f1_f7", f7, 64'h00080000_00000000);
      chk("f1_cnt", frame_cnt, 1);

      // conversion table as one frame
      for (int i = 0; i < 8; i++) send(tbl[i].data, 1'b0);
      chk("tbl_out_valid", out_valid, 1);
      chk("tbl_cnt", frame_cnt, 2);
      for (int i = 0; i < 8; i++) chk($sformatf("tbl_word%0d", i), fo[i], tbl[i].exp_word);
      @(posedge clk); #1;
      chk("tbl_drained", out_valid, 0);

      // backpressure: 16 samples with out_ready low
      out_ready = 1'b0;
      for (int i = 0; i < 16; i++) send(16'(100 + i), 1'b0);
      chk("full_in_ready", in_ready, 0);
      chk("full_f0_hold", f0, w(16'd100));
      chk("full_f7_hold", f7, w(16'd107));
      chk("full_cnt", frame_cnt, 3);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("full_xfer_f0", f0, w(16'd108));
      chk("full_xfer_f7", f7, w(16'd115));
      chk("full_xfer_cnt", frame_cnt, 4);
      chk("full_xfer_valid", out_valid, 1);
      chk("full_xfer_ready", in_ready, 1);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("full_drained", out_valid, 0);

      // SOF truncating a 3-sample partial frame
      for (int i = 0; i < 3; i++) send(16'(200 + i), 1'b0);
      send(16'd300, 1'b1);
      chk("sof_err_pulse", sof_err, 1);
      send(16'd301, 1'b0);
      chk("sof_err_clear", sof_err, 0);
      for (int i = 2; i < 8; i++) send(16'(300 + i), 1'b0);
      chk("sof_cnt", frame_cnt, 5);
      chk("sof_f0", f0, w(16'd300));
      chk("sof_f1", f1, w(16'd301));
      chk("sof_f7", f7, w(16'd307));
      chk("sof_pulses", sof_pulses, 1);
      // SOF at index 0 is a clean start
      send(16'd400, 1'b1);
      for (int i = 1; i < 8; i++) send(16'(400 + i), 1'b0);
      chk("sof0_pulses", sof_pulses, 1);
      chk("sof0_cnt", frame_cnt, 6);
      chk("sof0_f0", f0, w(16'd400));

      // reset with one frame pending and a partial frame in the buffer
      out_ready = 1'b0;
      for (int i = 0; i < 8; i++) send(16'(600 + i), 1'b0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) send(16'(700 + i), 1'b0);
      chk("pre_rst_valid", out_valid, 1);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("mid_rst_f0", f0, 0);
      chk("mid_rst_f7", f7, 0);
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_cnt", frame_cnt, 0);
      chk("mid_rst_sof_err", sof_err, 0);
      chk("mid_rst_in_ready", in_ready, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("post_rst_no_valid", out_valid, 0);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) send(16'(500 + i), 1'b0);
      chk("post_rst_cnt", frame_cnt, 1);
      chk("post_rst_f0", f0, w(16'd500));
      chk("post_rst_f4", f4, w(16'd504));
      chk("post_rst_f7", f7, w(16'd507));

      // 255 more frames back to back: count wraps, input never stalls
      mon_en = 1'b1;
      last_v = '0;
      for (int k = 0; k < 255 * 8; k++) begin
         last_v = 16'(k * 3);
         send(last_v, 1'b0);
      end
      mon_en = 1'b0;
      chk("wrap_cnt", frame_cnt, 0);
      chk("wrap_drops", drops, 0);
      chk("wrap_f7", f7, w(last_v));
      chk("wrap_valid", out_valid, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
